// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single SDRAM controller.
// Round-robin grant FSM, combinational command pass-through, and a tag
// FIFO that routes each returning readdatavalid to the requester that
// issued the read.
module sdram_port_arbiter #(
   parameter int MAX_PENDING = 8,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rq0_read_n,
   input  logic              rq0_write_n,
   input  logic [ADDR_W-1:0] rq0_address,
   input  logic [15:0]       rq0_writedata,
   input  logic [1:0]        rq0_byteenable,
   output logic              rq0_waitrequest,
   output logic              rq0_readdatavalid,
   input  logic              rq1_read_n,
   input  logic              rq1_write_n,
   input  logic [ADDR_W-1:0] rq1_address,
   input  logic [15:0]       rq1_writedata,
   input  logic [1:0]        rq1_byteenable,
   output logic              rq1_waitrequest,
   output logic              rq1_readdatavalid,
   output logic [15:0]       rq_readdata,
   output logic              sdram_read_n,
   output logic              sdram_write_n,
   output logic              sdram_chipselect,
   output logic [ADDR_W-1:0] sdram_address,
   output logic [15:0]       sdram_writedata,
   output logic [1:0]        sdram_byteenable,
   input  logic              sdram_waitrequest,
   input  logic              sdram_readdatavalid,
   input  logic [15:0]       sdram_readdata,
   output logic              busy,
   output logic              err_orphan
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = $clog2(MAX_PENDING) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

   typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;            // requester served by the last accepted command
   logic [MAX_PENDING-1:0] tag_mem_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic                   err_orphan_q;

   logic wr0_s, rd0_s, act0_s, can0_s;
   logic wr1_s, rd1_s, act1_s, can1_s;
   logic full_s, empty_s;
   logic gnt_id_s, cmd_valid_s, cmd_read_s, accept_s;
   logic push_s, pop_s, head_s;
   logic own_act_s, oth_act_s, oth_can_s;

   // A write beats a simultaneous read; a read can only issue while a tag slot is free.
   assign wr0_s   = ~rq0_write_n;
   assign rd0_s   = ~rq0_read_n & rq0_write_n;
   assign act0_s  = wr0_s | rd0_s;
   assign wr1_s   = ~rq1_write_n;
   assign rd1_s   = ~rq1_read_n & rq1_write_n;
   assign act1_s  = wr1_s | rd1_s;
   assign full_s  = (count_q == FULL_CNT);
   assign empty_s = (count_q == {CNT_W{1'b0}});
   assign can0_s  = wr0_s | (rd0_s & ~full_s);
   assign can1_s  = wr1_s | (rd1_s & ~full_s);

   assign own_act_s = gnt_id_s ? act1_s : act0_s;
   assign oth_act_s = gnt_id_s ? act0_s : act1_s;
   assign oth_can_s = gnt_id_s ? can0_s : can1_s;

   assign accept_s = cmd_valid_s & ~sdram_waitrequest;
   assign push_s   = accept_s & cmd_read_s;
   assign pop_s    = sdram_readdatavalid & ~empty_s;
   assign head_s   = tag_mem_q[rd_ptr_q];

   assign rq0_readdatavalid = pop_s & ~head_s;
   assign rq1_readdatavalid = pop_s & head_s;
   assign rq_readdata       = sdram_readdata;
   assign busy              = reset_n & (act0_s | act1_s | ~empty_s);
   assign err_orphan        = err_orphan_q;

   // Route the granted requester's command straight onto the SDRAM port.
   always_comb begin
      gnt_id_s         = 1'b0;
      cmd_valid_s      = 1'b0;
      cmd_read_s       = 1'b0;
      sdram_read_n     = 1'b1;
      sdram_write_n    = 1'b1;
      sdram_chipselect = 1'b0;
      sdram_address    = {ADDR_W{1'b0}};
      sdram_writedata  = 16'h0000;
      sdram_byteenable = 2'b00;
      rq0_waitrequest  = 1'b1;
      rq1_waitrequest  = 1'b1;
      case (state_q)
         G0: begin
            gnt_id_s = 1'b0;
            if (can0_s) begin
               cmd_valid_s      = 1'b1;
               cmd_read_s       = rd0_s;
               sdram_chipselect = 1'b1;
               sdram_read_n     = ~rd0_s;
               sdram_write_n    = ~wr0_s;
               sdram_address    = rq0_address;
               sdram_writedata  = rq0_writedata;
               sdram_byteenable = rq0_byteenable;
               rq0_waitrequest  = sdram_waitrequest;
            end else begin
               cmd_valid_s = 1'b0;
            end
         end
         G1: begin
            gnt_id_s = 1'b1;
            if (can1_s) begin
               cmd_valid_s      = 1'b1;
               cmd_read_s       = rd1_s;
               sdram_chipselect = 1'b1;
               sdram_read_n     = ~rd1_s;
               sdram_write_n    = ~wr1_s;
               sdram_address    = rq1_address;
               sdram_writedata  = rq1_writedata;
               sdram_byteenable = rq1_byteenable;
               rq1_waitrequest  = sdram_waitrequest;
            end else begin
               cmd_valid_s = 1'b0;
            end
         end
         default: begin
            gnt_id_s = 1'b0;
         end
      endcase
   end

   // Grant next-state: hold while a stalled command is presented, otherwise round-robin.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (act0_s && act1_s) begin
               state_d = last_q ? G0 : G1;
            end else if (act0_s) begin
               state_d = G0;
            end else if (act1_s) begin
               state_d = G1;
            end else begin
               state_d = IDLE;
            end
         end
         G0, G1: begin
            if (cmd_valid_s) begin
               if (accept_s) begin
                  last_d = gnt_id_s;
                  if (oth_act_s) begin
                     state_d = gnt_id_s ? G0 : G1;
                  end else if (own_act_s) begin
                     state_d = state_q;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = state_q;
               end
            end else if (oth_can_s) begin
               state_d = gnt_id_s ? G0 : G1;
            end else if (own_act_s) begin
               state_d = state_q;
            end else if (oth_act_s) begin
               state_d = gnt_id_s ? G0 : G1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Grant state and round-robin memory; after reset rq0 wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Tag FIFO of outstanding reads plus the sticky orphan-response flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_mem_q    <= {MAX_PENDING{1'b0}};
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         err_orphan_q <= 1'b0;
      end else begin
         if (push_s) begin
            tag_mem_q[wr_ptr_q] <= gnt_id_s;
            wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         err_orphan_q <= err_orphan_q | (sdram_readdatavalid & empty_s);
      end
   end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter MAX_PENDING, default 8, SHALL set the maximum number of accepted reads awaiting readdatavalid (power of 2, 2..32).
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width on all ports.
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 rqN_read_n (N=0,1)  in  1  requester N read command, active-low.
REQ-006 rqN_write_n  in  1  requester N write command, active-low.
REQ-007 rqN_address  in  ADDR_W  requester N word address.
REQ-008 rqN_writedata  in  16  requester N write data.
REQ-009 rqN_byteenable  in  2  requester N byte enables.
REQ-010 rqN_waitrequest  out  1  stall to requester N.
REQ-011 rqN_readdatavalid  out  1  read data for requester N valid this cycle.
REQ-012 rq_readdata  out  16  shared read data, equal to sdram_readdata.
REQ-013 sdram_read_n / sdram_write_n  out  1 each  Avalon-MM command to SDRAM, active-low.
REQ-014 sdram_chipselect  out  1  high whenever a command is driven.
REQ-015 sdram_address / sdram_writedata / sdram_byteenable  out  ADDR_W/16/2  command fields.
REQ-016 sdram_waitrequest / sdram_readdatavalid / sdram_readdata  in  1/1/16  SDRAM responses.
REQ-017 busy  out  1  high while any request is active or any read is pending.
REQ-018 err_orphan  out  1  sticky: sdram_readdatavalid arrived with no pending read.

Function
REQ-019 Requester N is active when rqN_read_n=0 or rqN_write_n=0; if both are 0, the write SHALL win and the read SHALL be ignored for that cycle.
REQ-020 Grant FSM states IDLE, G0, G1; IDLE -> G0/G1 when a requester is active, chosen per REQ-021.
REQ-021 Round-robin: on a tie the requester not served by the last accepted command SHALL win; after reset rq0 has priority.
REQ-022 Once in Gn with a command presented, grant SHALL NOT change until sdram_waitrequest=0 (command stable, Avalon rule).
REQ-023 On acceptance (command driven and sdram_waitrequest=0): move to the other Gm if m active, else stay Gn if n still active, else IDLE.
REQ-024 Granted command SHALL pass combinationally to the sdram_* outputs, zero added latency; rqN_waitrequest = sdram_waitrequest for the granted requester, 1 for the other.
REQ-025 In IDLE: sdram_read_n=1, sdram_write_n=1, sdram_chipselect=0, address/writedata/byteenable=0.
REQ-026 Every accepted read SHALL push the granted ID into a tag FIFO of depth MAX_PENDING.
REQ-027 On sdram_readdatavalid=1, the FIFO head SHALL be popped and rqHEAD_readdatavalid asserted the same cycle; the other rqN_readdatavalid stays 0.
REQ-028 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-029 FIFO full: reads SHALL be withheld (sdram_read_n=1, requester waitrequest=1); writes still pass; if the granted requester is read-blocked and the other has a write, grant SHALL move to the writer.
REQ-030 sdram_readdatavalid with FIFO empty: no rqN_readdatavalid, err_orphan set until reset.
REQ-031 Tag count SHALL be $clog2(MAX_PENDING)+1 bits; pointers wrap modulo MAX_PENDING.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, priority rq0, FIFO empty, err_orphan=0, busy=0, outputs per REQ-025, rqN_waitrequest=1, rqN_readdatavalid=0.
REQ-033 Reset mid-operation SHALL discard pending tags; subsequent late readdatavalid SHALL set err_orphan.
REQ-034 Outputs SHALL reach defined values within one clk of reset_n deassertion; no command issued in the deassertion cycle.

Verification
REQ-035 rq0 reads 0x61A80, waitrequest 0 -> sdram_address=0x61A80 same cycle, tag 0 pushed; readdatavalid 3 cycles later, data 0x0123 -> rq0_readdatavalid=1, rq_readdata=0x0123, rq1_readdatavalid=0.
REQ-036 Both continuously reading, no stall -> accepted grants alternate 0,1,0,1; readdatavalids route in the same order.
REQ-037 rq1 writes 0x493E0 with sdram_waitrequest=1 for 4 cycles while rq0 requests -> command held stable 5 cycles, rq0_waitrequest=1 throughout, rq0 granted next.
REQ-038 MAX_PENDING=8, 8 reads accepted, no readdatavalid -> 9th read withheld; rq1 write accepted; one readdatavalid frees slot, 9th read issued next cycle.
REQ-039 sdram_readdatavalid with empty FIFO -> err_orphan=1 held; reset_n pulse -> err_orphan=0, busy=0, IDLE outputs.
